int_return_ctrl: RTL and testbench
==================================

Name: int_return_ctrl

Overview:
- Sits directly downstream of the interruption module, between it and the PC-select logic.
- On an accepted interrupt request it saves the resume address on a small return-address stack and redirects the PC to the handler address.
- On a decoded RETI it pops the stack, redirects the PC back to the saved address, and pulses s_finished so the interruption module can clear the serviced source.
- Nesting is supported up to DEPTH levels, for example a syscall issued inside a handler.

Parameters:
ADDR_W, 10, width of instruction addresses (handler address, PC).
DEPTH, 4, return-address stack entries.
DEPTH_W, 3, width of depth counter; must hold 0..DEPTH.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-low reset (asserted when 0).
s_interruption  in  1  request level from interruption module; held high until serviced.
dir_int  in  ADDR_W  handler address; valid while s_interruption=1.
pc_ret  in  ADDR_W  address to resume at (next sequential PC) in the current cycle.
reti  in  1  decoded return-from-interrupt; one-cycle pulse.
redirect  out  1  one-cycle pulse: PC must load redirect_addr.
redirect_addr  out  ADDR_W  target for redirect; holds its last value otherwise.
s_finished  out  1  one-cycle pulse on each completed return.
in_service  out  1  high when depth>0.
depth  out  DEPTH_W  current stack occupancy.
stack_ovf  out  1  sticky: a request was blocked because the stack was full.
stack_unf  out  1  sticky: reti arrived with depth=0.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=RUN; redirect=0, redirect_addr=0, s_finished=0, depth=0, in_service=0, stack_ovf=0, stack_unf=0.
  - pending=0, req_q=0, all stack entries=0.
  - Reset mid-service discards all saved addresses; nothing is replayed.
- Request detection:
  - req_q registers s_interruption each cycle.
  - A rising edge (s_interruption=1 and req_q=0) sets pending.
  - pending is cleared only when the request is accepted.
  - A held level therefore produces exactly one entry.
- FSM states: RUN (depth=0), ENTER (1 cycle), ISR (depth>0), EXIT (1 cycle).
- Accept, from RUN or ISR:
  - Condition: (rising edge or pending) and depth<DEPTH and reti=0.
  - At that clock edge: stack[depth]<=pc_ret, depth<=depth+1, redirect_addr<=dir_int, redirect<=1, pending<=0, go to ENTER.
  - Latency: redirect is high the cycle after the request edge is sampled.
- ENTER: redirect falls to 0; next state ISR. reti and new requests arriving in this cycle are held (reti is lost; requests stay pending).
- Return, from ISR with reti=1:
  - Pop: redirect_addr<=stack[depth-1], depth<=depth-1, redirect<=1, s_finished<=1, go to EXIT.
- EXIT: redirect and s_finished fall to 0; next state ISR if depth>0, else RUN.
- Simultaneous reti and request in ISR: the return has priority. The request becomes pending and is accepted at the earliest from the cycle after EXIT (tail-chaining).
- Full stack (depth=DEPTH) with a request: no push; stack_ovf<=1; pending held until a pop frees an entry, then accepted normally.
- reti in RUN (depth=0): stack_unf<=1; no redirect, no s_finished, state unchanged.
- Wrap-around: none. depth saturates in 0..DEPTH; there are no pointer wraps.
- in_service=(depth!=0), combinational from depth.
- stack_ovf and stack_unf clear only on reset.
- pc_ret and dir_int are sampled only on the accept edge.

Test Plan:
1. Reset=0 pulse mid-cycle, then release -> all outputs 0 immediately (async); depth=0, state RUN.
2. s_interruption 0->1 held 5 cycles, dir_int=0x3FC, pc_ret=0x012 -> exactly one redirect pulse with redirect_addr=0x3FC one cycle after the edge; depth=1, in_service=1.
3. From test 2, reti pulse -> next cycle redirect=1, redirect_addr=0x012, s_finished=1 for exactly one cycle; depth=0, in_service=0.
4. Nested: accept 0x3FC (pc_ret 0x010), then 0x3FD (pc_ret 0x3FC+3=0x3FF), then two reti -> returns to 0x3FF then 0x010; two s_finished pulses.
5. Fill DEPTH=4 entries, raise a 5th request -> stack_ovf=1, no redirect; one reti -> pop and return first, then the pending request is accepted two cycles later; depth back to 4.
6. reti with depth=0 -> stack_unf=1, redirect=0, s_finished=0; same-cycle reti and request rising edge in ISR -> return redirect first, request redirect after EXIT.

Source files
------------

// File: rtl/int_return_ctrl_if.sv
// Bundle between the interruption module, the decoder,
// the PC-select logic and the return controller.
interface int_return_ctrl_if #(
    parameter int ADDR_W  = 10,
    parameter int DEPTH_W = 3
);
    logic              s_interruption;
    logic [ADDR_W-1:0] dir_int;
    logic [ADDR_W-1:0] pc_ret;
    logic              reti;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_addr;
    logic              s_finished;
    logic              in_service;
    logic [DEPTH_W-1:0] depth;
    logic              stack_ovf;
    logic              stack_unf;

    modport master (
        output s_interruption,
        output dir_int,
        output pc_ret,
        output reti,
        input  redirect,
        input  redirect_addr,
        input  s_finished,
        input  in_service,
        input  depth,
        input  stack_ovf,
        input  stack_unf
    );

    modport slave (
        input  s_interruption,
        input  dir_int,
        input  pc_ret,
        input  reti,
        output redirect,
        output redirect_addr,
        output s_finished,
        output in_service,
        output depth,
        output stack_ovf,
        output stack_unf
    );
endinterface

// File: rtl/int_return_ctrl.sv
// Interrupt entry/return controller: saves resume addresses
// on a small stack and redirects the PC to handler / back.
module int_return_ctrl #(
    parameter int ADDR_W  = 10,
    parameter int DEPTH   = 4,
    parameter int DEPTH_W = 3
) (
    input logic              clk,
    input logic              reset,
    int_return_ctrl_if.slave bus
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [DEPTH_W-1:0] FULL = DEPTH_W'(DEPTH);

    typedef enum logic [1:0] {
        RUN,
        ENTER,
        ISR,
        EXIT
    } state_t;

    state_t state, state_nx;

    logic               req_q;
    logic               pending, pending_nx;
    logic [ADDR_W-1:0]  stack [DEPTH];
    logic [DEPTH_W-1:0] depth_q, depth_nx;
    logic [DEPTH_W-1:0] depth_m1;
    logic [ADDR_W-1:0]  addr_q, addr_nx;
    logic               redirect_q, redirect_nx;
    logic               fin_q, fin_nx;
    logic               ovf_q, ovf_nx;
    logic               unf_q, unf_nx;
    logic               rise, want, active, full;
    logic               ret_ok, acc_ok, unf_hit, push;
    logic [IDX_W-1:0]   push_idx, pop_idx;

    assign rise     = bus.s_interruption & ~req_q;
    assign want     = rise | pending;
    assign active   = (state == RUN) || (state == ISR);
    assign full     = (depth_q == FULL);
    assign depth_m1 = depth_q - DEPTH_W'(1);
    assign push_idx = depth_q[IDX_W-1:0];
    assign pop_idx  = depth_m1[IDX_W-1:0];

    // Return beats a same-cycle request; the request waits as pending.
    assign ret_ok  = (state == ISR) && bus.reti;
    assign unf_hit = (state == RUN) && bus.reti;
    assign acc_ok  = active && want && !full && !bus.reti;

    always_comb begin
        state_nx    = state;
        pending_nx  = pending | rise;
        depth_nx    = depth_q;
        addr_nx     = addr_q;
        redirect_nx = 1'b0;
        fin_nx      = 1'b0;
        ovf_nx      = ovf_q | (active && want && full);
        unf_nx      = unf_q;
        push        = 1'b0;

        unique case (state)
            ENTER:   state_nx = ISR;
            EXIT:    state_nx = (depth_q != '0) ? ISR : RUN;
            default: ;
        endcase

        unique case (1'b1)
            ret_ok: begin
                addr_nx     = stack[pop_idx];
                depth_nx    = depth_m1;
                redirect_nx = 1'b1;
                fin_nx      = 1'b1;
                state_nx    = EXIT;
            end
            acc_ok: begin
                push        = 1'b1;
                addr_nx     = bus.dir_int;
                depth_nx    = depth_q + DEPTH_W'(1);
                redirect_nx = 1'b1;
                pending_nx  = 1'b0;
                state_nx    = ENTER;
            end
            unf_hit: unf_nx = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= RUN;
            req_q      <= 1'b0;
            pending    <= 1'b0;
            depth_q    <= '0;
            addr_q     <= '0;
            redirect_q <= 1'b0;
            fin_q      <= 1'b0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                stack[i] <= '0;
            end
        end else begin
            state      <= state_nx;
            req_q      <= bus.s_interruption;
            pending    <= pending_nx;
            depth_q    <= depth_nx;
            addr_q     <= addr_nx;
            redirect_q <= redirect_nx;
            fin_q      <= fin_nx;
            ovf_q      <= ovf_nx;
            unf_q      <= unf_nx;
            if (push) begin
                stack[push_idx] <= bus.pc_ret;
            end
        end
    end

    assign bus.redirect      = redirect_q;
    assign bus.redirect_addr = addr_q;
    assign bus.s_finished    = fin_q;
    assign bus.in_service    = (depth_q != '0);
    assign bus.depth         = depth_q;
    assign bus.stack_ovf     = ovf_q;
    assign bus.stack_unf     = unf_q;
endmodule

// File: tb/tb_int_return_ctrl.sv
// Bench for int_return_ctrl: fixed vector table, corner
// sequences, and random traffic against a stack-based model.
module tb_int_return_ctrl;
    localparam int ADDR_W  = 10;
    localparam int DEPTH   = 4;
    localparam int DEPTH_W = 3;
    localparam logic H = 1'b1;
    localparam logic L = 1'b0;
    localparam logic [ADDR_W-1:0] Z = '0;

    typedef logic [ADDR_W+DEPTH_W+4:0] obs_t;

    typedef struct {
        logic              s;
        logic [ADDR_W-1:0] dir;
        logic [ADDR_W-1:0] pc;
        logic              reti;
        logic              red;
        logic [ADDR_W-1:0] addr;
        logic              fin;
        logic [DEPTH_W-1:0] dep;
        logic              ovf;
        logic              unf;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    int_return_ctrl_if #(.ADDR_W(ADDR_W), .DEPTH_W(DEPTH_W)) bus ();

    int_return_ctrl #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .DEPTH_W(DEPTH_W)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Reference model: a queue as the return stack; the cycle after
    // any redirect is a dead cycle in which nothing is accepted.
    logic [ADDR_W-1:0] m_stack[$];
    logic              m_pending, m_prev, m_red, m_fin, m_ovf, m_unf;
    logic [ADDR_W-1:0] m_addr;

    function automatic obs_t pack(logic red, logic [ADDR_W-1:0] a,
                                  logic fin, logic ins,
                                  logic [DEPTH_W-1:0] d,
                                  logic o, logic u);
        return {red, a, fin, ins, d, o, u};
    endfunction

    function automatic obs_t actual();
        return pack(bus.redirect, bus.redirect_addr, bus.s_finished,
                    bus.in_service, bus.depth, bus.stack_ovf,
                    bus.stack_unf);
    endfunction

    function automatic obs_t model_exp();
        int n;
        n = m_stack.size();
        return pack(m_red, m_addr, m_fin, n != 0, DEPTH_W'(n),
                    m_ovf, m_unf);
    endfunction

    task automatic model_reset();
        m_stack.delete();
        m_pending = 1'b0;
        m_prev    = 1'b0;
        m_red     = 1'b0;
        m_fin     = 1'b0;
        m_ovf     = 1'b0;
        m_unf     = 1'b0;
        m_addr    = '0;
    endtask

    task automatic model_step(input logic s, input logic [ADDR_W-1:0] dir,
                              input logic [ADDR_W-1:0] pc, input logic r);
        logic rise, want, busy, full;
        rise = s && !m_prev;
        want = rise || m_pending;
        busy = m_red;
        full = (m_stack.size() == DEPTH);
        m_red  = 1'b0;
        m_fin  = 1'b0;
        m_prev = s;
        if (rise) m_pending = 1'b1;
        if (!busy) begin
            if (want && full) m_ovf = 1'b1;
            if (r) begin
                if (m_stack.size() > 0) begin
                    m_addr = m_stack.pop_back();
                    m_red  = 1'b1;
                    m_fin  = 1'b1;
                end else begin
                    m_unf = 1'b1;
                end
            end else if (want && !full) begin
                m_stack.push_back(pc);
                m_addr    = dir;
                m_red     = 1'b1;
                m_pending = 1'b0;
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)",
                     name, got, exp, $time);
        end
    endtask

    task automatic tick(input logic s, input logic [ADDR_W-1:0] dir,
                        input logic [ADDR_W-1:0] pc, input logic r);
        bus.s_interruption = s;
        bus.dir_int        = dir;
        bus.pc_ret         = pc;
        bus.reti           = r;
        @(posedge clk);
        model_step(s, dir, pc, r);
        #1;
    endtask

    task automatic cycle(input string name, input logic s,
                         input logic [ADDR_W-1:0] dir,
                         input logic [ADDR_W-1:0] pc, input logic r);
        tick(s, dir, pc, r);
        check(name, 32'(actual()), 32'(model_exp()));
    endtask

    function automatic logic [31:0] key();
        return 32'({bus.redirect, bus.redirect_addr,
                    bus.s_finished, bus.depth});
    endfunction

    function automatic logic [31:0] mk(logic red, logic [ADDR_W-1:0] a,
                                       logic fin, logic [DEPTH_W-1:0] d);
        return 32'({red, a, fin, d});
    endfunction

    task automatic do_reset();
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check("async_reset", 32'(actual()), 32'(0));
        bus.s_interruption = 1'b0;
        bus.dir_int        = '0;
        bus.pc_ret         = '0;
        bus.reti           = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    vec_t tbl[19];

    initial begin
        tbl[0]  = '{H, 10'h3FC, 10'h012, L, H, 10'h3FC, L, 3'd1, L, L};
        tbl[1]  = '{H, 10'h3FC, 10'h012, L, L, 10'h3FC, L, 3'd1, L, L};
        tbl[2]  = '{H, 10'h3FC, 10'h012, L, L, 10'h3FC, L, 3'd1, L, L};
        tbl[3]  = '{H, 10'h3FC, 10'h012, L, L, 10'h3FC, L, 3'd1, L, L};
        tbl[4]  = '{H, 10'h3FC, 10'h012, L, L, 10'h3FC, L, 3'd1, L, L};
        tbl[5]  = '{L, Z, Z, L, L, 10'h3FC, L, 3'd1, L, L};
        tbl[6]  = '{L, Z, Z, H, H, 10'h012, H, 3'd0, L, L};
        tbl[7]  = '{L, Z, Z, L, L, 10'h012, L, 3'd0, L, L};
        tbl[8]  = '{H, 10'h3FC, 10'h010, L, H, 10'h3FC, L, 3'd1, L, L};
        tbl[9]  = '{L, Z, Z, L, L, 10'h3FC, L, 3'd1, L, L};
        tbl[10] = '{L, Z, Z, L, L, 10'h3FC, L, 3'd1, L, L};
        tbl[11] = '{H, 10'h3FD, 10'h3FF, L, H, 10'h3FD, L, 3'd2, L, L};
        tbl[12] = '{L, Z, Z, L, L, 10'h3FD, L, 3'd2, L, L};
        tbl[13] = '{L, Z, Z, H, H, 10'h3FF, H, 3'd1, L, L};
        tbl[14] = '{L, Z, Z, L, L, 10'h3FF, L, 3'd1, L, L};
        tbl[15] = '{L, Z, Z, H, H, 10'h010, H, 3'd0, L, L};
        tbl[16] = '{L, Z, Z, L, L, 10'h010, L, 3'd0, L, L};
        tbl[17] = '{L, Z, Z, H, L, 10'h010, L, 3'd0, L, H};
        tbl[18] = '{L, Z, Z, L, L, 10'h010, L, 3'd0, L, H};

        bus.s_interruption = 1'b0;
        bus.dir_int        = '0;
        bus.pc_ret         = '0;
        bus.reti           = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        do_reset();

        // single entry, return, nesting, underflow
        for (int i = 0; i < 19; i++) begin
            tick(tbl[i].s, tbl[i].dir, tbl[i].pc, tbl[i].reti);
            check($sformatf("vec%0d", i), 32'(actual()),
                  32'(pack(tbl[i].red, tbl[i].addr, tbl[i].fin,
                           tbl[i].dep != 0, tbl[i].dep,
                           tbl[i].ovf, tbl[i].unf)));
        end

        // fill the stack, overflow, pop, then tail-chained accept
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            cycle("fill_req", H, ADDR_W'(10'h100 + i),
                  ADDR_W'(10'h040 + i), L);
            cycle("fill_gap", L, Z, Z, L);
        end
        cycle("ovf_req", H, 10'h2AA, 10'h055, L);
        check("ovf_state", 32'({bus.redirect, bus.stack_ovf, bus.depth}),
              32'({L, H, 3'd4}));
        cycle("full_pop", H, 10'h2AA, 10'h055, H);
        check("full_pop_key", key(), mk(H, 10'h043, H, 3'd3));
        cycle("full_exit", H, 10'h2AA, 10'h055, L);
        check("full_exit_key", key(), mk(L, 10'h043, L, 3'd3));
        cycle("tail_acc", H, 10'h2AA, 10'h055, L);
        check("tail_acc_key", key(), mk(H, 10'h2AA, L, 3'd4));
        cycle("tail_enter", H, 10'h2AA, 10'h055, L);
        check("tail_enter_key", key(), mk(L, 10'h2AA, L, 3'd4));

        // same-cycle reti and new request while in service
        do_reset();
        cycle("sc_acc", H, 10'h3FC, 10'h012, L);
        cycle("sc_enter", L, Z, Z, L);
        cycle("sc_isr", L, Z, Z, L);
        cycle("sc_both", H, 10'h3FD, 10'h200, H);
        check("sc_ret_first", key(), mk(H, 10'h012, H, 3'd0));
        cycle("sc_exit", H, 10'h3FD, 10'h201, L);
        check("sc_exit_key", key(), mk(L, 10'h012, L, 3'd0));
        cycle("sc_chain", H, 10'h3FD, 10'h202, L);
        check("sc_chain_key", key(), mk(H, 10'h3FD, L, 3'd1));

        // random traffic
        do_reset();
        begin
            logic s;
            s = 1'b0;
            for (int i = 0; i < 3000; i++) begin
                if ($urandom_range(0, 3) == 0) s = ~s;
                cycle("rand", s, ADDR_W'($urandom),
                      ADDR_W'($urandom), $urandom_range(0, 5) == 0);
                if ($urandom_range(0, 599) == 0) begin
                    do_reset();
                    s = 1'b0;
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
